// File: rtl/uart_rx_gen.sv
// uart_rx_gen: oversampling UART receiver (start, DATA_W LSB-first data, optional parity, 1-2 stop bits) with one-cycle DATA_VLD/Par_Err/Stp_Err strobes and BUSY
module uart_rx_gen #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               DATA_VLD,
  output logic               Par_Err,
  output logic               Stp_Err,
  output logic               BUSY
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic rx_m, rx_s, s_a, s_b, samp_bit;
  logic [PRESC_W-1:0] p_q, edge_cnt, half;
  logic par_en_q, par_typ_q, stop2_q, stop_idx, par_fail, stp_fail;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] data_q;
  logic maj, bit_end, decide, go, done, sf, good;
  assign half     = p_q >> 1;
  assign maj      = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign bit_end  = edge_cnt == p_q - PRESC_W'(1);
  assign decide   = edge_cnt == half + PRESC_W'(1);
  assign done     = state == STOP && bit_end && stop_idx == stop2_q;
  assign go       = nxt == START && state != START;
  assign sf       = stp_fail | ~samp_bit;
  assign good     = done & ~par_fail & ~sf;
  assign BUSY     = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = rx_s ? IDLE : START;
      START:   nxt = (decide && maj) ? IDLE : bit_end ? DATA : START;
      DATA:    nxt = (bit_end && bit_cnt == LAST_BIT) ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  nxt = bit_end ? STOP : PARITY;
      // the final stop cycle doubles as an IDLE cycle so back-to-back frames keep exact bit alignment
      STOP:    nxt = (bit_end && stop_idx == stop2_q) ? (rx_s ? IDLE : START) : STOP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      s_a       <= 1'b1;
      s_b       <= 1'b1;
      samp_bit  <= 1'b1;
      p_q       <= '0;
      edge_cnt  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_idx  <= 1'b0;
      par_fail  <= 1'b0;
      stp_fail  <= 1'b0;
      bit_cnt   <= '0;
      data_q    <= '0;
      P_DATA    <= '0;
      DATA_VLD  <= 1'b0;
      Par_Err   <= 1'b0;
      Stp_Err   <= 1'b0;
    end else begin
      rx_m     <= RX_IN;
      rx_s     <= rx_m;
      s_a      <= (edge_cnt == half - PRESC_W'(1)) ? rx_s : s_a;
      s_b      <= (edge_cnt == half) ? rx_s : s_b;
      samp_bit <= decide ? maj : samp_bit;
      edge_cnt <= (go || state == IDLE || bit_end) ? '0 : edge_cnt + PRESC_W'(1);
      if (state == DATA && bit_end) begin
        data_q  <= {samp_bit, data_q[DATA_W-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (state == PARITY && bit_end) par_fail <= (^data_q ^ par_typ_q) != samp_bit;
      if (state == STOP && bit_end) begin
        stop_idx <= 1'b1;
        stp_fail <= sf;
      end
      DATA_VLD <= good;
      Par_Err  <= done & par_fail;
      Stp_Err  <= done & sf;
      if (good) P_DATA <= data_q;
      if (go) begin
        p_q       <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
        stop_idx  <= 1'b0;
        par_fail  <= 1'b0;
        stp_fail  <= 1'b0;
        bit_cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_gen.sv
// tb_uart_rx_gen: scoreboard bench for uart_rx_gen with 8-bit and 9-bit instances
module tb_uart_rx_gen;
  typedef struct packed {logic [1:0] kind; logic [8:0] data;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, rx8 = 1'b1, rx9 = 1'b1;
  logic [5:0] presc = 6'd16;
  logic par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
  logic [7:0] pd8;
  logic [8:0] pd9;
  logic v8, pe8, se8, b8, v9, pe9, se9, b9;
  exp_t q8[$], q9[$];
  int t9[$];
  int cyc = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  uart_rx_gen #(.DATA_W(8), .PRESC_W(6)) u8 (
    .CLK(clk), .RST(rst_n), .RX_IN(rx8), .PRESCALE(presc), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .P_DATA(pd8), .DATA_VLD(v8), .Par_Err(pe8), .Stp_Err(se8), .BUSY(b8));
  uart_rx_gen #(.DATA_W(9), .PRESC_W(6)) u9 (
    .CLK(clk), .RST(rst_n), .RX_IN(rx9), .PRESCALE(presc), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .P_DATA(pd9), .DATA_VLD(v9), .Par_Err(pe9), .Stp_Err(se9), .BUSY(b9));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask
  task automatic check_evt(input int line, input logic [2:0] got, input logic [8:0] pd);
    exp_t e;
    total++;
    if ((line == 0 ? q8.size() : q9.size()) == 0) begin
      bad++;
      $display("FAIL unexpected_strobe dut%0d got vld/stp/par=%b want none", line, got);
      return;
    end
    e = (line == 0) ? q8.pop_front() : q9.pop_front();
    if (got !== {e.kind == 2'd0, e.kind}) begin
      bad++;
      $display("FAIL strobes dut%0d got vld/stp/par=%b want=%b", line, got, {e.kind == 2'd0, e.kind});
    end
    if (e.kind == 2'd0) chk($sformatf("p_data_dut%0d", line), 32'(pd), 32'(e.data));
  endtask
  always @(posedge clk) begin
    #1;
    if (v8 | pe8 | se8) check_evt(0, {v8, se8, pe8}, {1'b0, pd8});
    if (v9 | pe9 | se9) check_evt(1, {v9, se9, pe9}, pd9);
    if (v9) t9.push_back(cyc);
  end
  task automatic set_line(input int line, input logic v);
    if (line == 0) rx8 = v;
    else rx9 = v;
  endtask
  task automatic drive_bit(input int line, input logic v, input int p);
    set_line(line, v);
    repeat (p) @(negedge clk);
  endtask
  task automatic send(input int line, input int p, input logic [8:0] d, input bit pe, input bit typ,
                      input bit s2, input bit flip_par, input bit [1:0] stop_low);
    int w;
    logic [8:0] dm;
    bit par_sent, pf, sf;
    exp_t e;
    w = (line == 0) ? 8 : 9;
    dm = (line == 0) ? {1'b0, d[7:0]} : d;
    par_sent = (^dm) ^ typ ^ flip_par;
    pf = pe && (par_sent != ((^dm) ^ typ));
    sf = stop_low[0] || (s2 && stop_low[1]);
    e.kind = {sf, pf};
    e.data = dm;
    if (line == 0) q8.push_back(e);
    else q9.push_back(e);
    presc = 6'(p);
    par_en = pe;
    par_typ = typ;
    stop2 = s2;
    drive_bit(line, 1'b0, p);
    for (int i = 0; i < w; i++) drive_bit(line, dm[i], p);
    if (pe) drive_bit(line, par_sent, p);
    drive_bit(line, ~stop_low[0], p);
    if (s2) drive_bit(line, ~stop_low[1], p);
    set_line(line, 1'b1);
  endtask
  task automatic wait_done();
    int k = 0;
    while ((q8.size() != 0 || q9.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout_pending", 32'(q8.size() + q9.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int p, gap;
    bit saw;
    repeat (3) @(negedge clk);
    chk("rst_p_data8", 32'(pd8), 32'd0);
    chk("rst_p_data9", 32'(pd9), 32'd0);
    chk("rst_strobes8", {29'd0, v8, pe8, se8}, 32'd0);
    chk("rst_strobes9", {29'd0, v9, pe9, se9}, 32'd0);
    chk("rst_busy", {30'd0, b8, b9}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", {30'd0, b8, b9}, 32'd0);
    send(0, 32, 9'h0A5, 1, 0, 0, 0, 2'b00);
    wait_done();
    send(0, 32, 9'h0A5, 1, 0, 0, 1, 2'b00);
    wait_done();
    chk("p_data_hold_par_err", 32'(pd8), 32'h0A5);
    send(0, 16, 9'h03C, 0, 0, 1, 0, 2'b10);
    wait_done();
    chk("p_data_hold_stp_err", 32'(pd8), 32'h0A5);
    presc = 6'd32;
    rx8 = 1'b0;
    repeat (4) @(negedge clk);
    rx8 = 1'b1;
    saw = 1'b0;
    repeat (16 + 2 + 6) begin
      @(negedge clk);
      saw |= b8;
    end
    chk("glitch_busy_seen", 32'(saw), 32'd1);
    chk("glitch_busy_dropped", 32'(b8), 32'd0);
    repeat (40) @(negedge clk);
    chk("glitch_p_data", 32'(pd8), 32'h0A5);
    t9.delete();
    send(1, 8, 9'h1FF, 1, 1, 0, 0, 2'b00);
    send(1, 8, 9'h001, 1, 1, 0, 0, 2'b00);
    wait_done();
    chk("b2b_pulses", 32'(t9.size()), 32'd2);
    gap = (t9.size() >= 2) ? t9[1] - t9[0] : -1;
    chk("b2b_gap", 32'(gap), 32'd96);
    presc = 6'd16;
    par_en = 1'b0;
    stop2 = 1'b0;
    drive_bit(0, 1'b0, 16);
    drive_bit(0, 1'b0, 16);
    drive_bit(0, 1'b1, 16);
    drive_bit(0, 1'b0, 16);
    drive_bit(0, 1'b1, 8);
    chk("mid_frame_busy", 32'(b8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_p_data", 32'(pd8), 32'd0);
    chk("mid_rst_outs", {28'd0, v8, pe8, se8, b8}, 32'd0);
    @(negedge clk);
    rx8 = 1'b1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(0, 16, 9'h05A, 0, 0, 0, 0, 2'b00);
    wait_done();
    for (int i = 0; i < 24; i++) begin
      p = 8 << $urandom_range(0, 2);
      send(i % 3 == 2 ? 1 : 0, p, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      repeat ($urandom_range(1, 3) * p) @(negedge clk);
    end
    wait_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_gen.md
Name: uart_rx_gen

Overview:
- Parametrised UART receive engine, successor to the fixed 8-bit receiver inside SYS_TOP.
- Oversamples RX_IN with a programmable prescale, deserialises LSB-first frames of configurable data width, with optional even/odd parity and one or two stop bits.
- Emits a one-cycle DATA_VLD strobe with P_DATA, or a one-cycle error strobe.
- Sits in the UART_CLK domain, feeding the system controller.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- PRESC_W, 6, width of PRESCALE; must hold the value 32.

Ports:
- CLK  input  1  oversampling clock (UART_CLK).
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line; idles high; asynchronous to CLK.
- PRESCALE  input  PRESC_W  oversample ratio; legal 8, 16, 32.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- STOP2  input  1  1 = two stop bits.
- P_DATA  output  DATA_W  received data; LSB first on the line.
- DATA_VLD  output  1  one-cycle strobe; P_DATA valid.
- Par_Err  output  1  one-cycle strobe; parity mismatch.
- Stp_Err  output  1  one-cycle strobe; a stop bit sampled low.
- BUSY  output  1  high while not in IDLE.

Behaviour:
- Reset values:
  - Synchroniser flops and the sampled bit are 1.
  - P_DATA = 0; DATA_VLD, Par_Err, Stp_Err and BUSY = 0.
  - FSM = IDLE.
- Reset acts immediately, including mid-frame. A partial frame is discarded and produces no strobes.
- Synchroniser: RX_IN passes through a 2-flop synchroniser (rx_s). All timing below refers to rx_s.
- Configuration: PRESCALE, PAR_EN, PAR_TYP and STOP2 are latched on the IDLE->START transition. Changes mid-frame take effect on the next frame.
- Counters:
  - edge_cnt runs 0..P-1, where P is the latched prescale. It wraps to 0 at P-1, and each wrap ends one bit period.
  - bit_cnt counts data bits 0..DATA_W-1.
- Sampling:
  - rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples and is registered at edge_cnt = P/2+1.
- FSM states and transitions:
  - IDLE: when rx_s = 0, go to START with edge_cnt = 0.
  - START: at the decision point, a sampled 1 is a glitch. Return to IDLE at once, with no strobes. Otherwise go to DATA at the end of the bit period.
  - DATA: shift the sampled bit into bit position bit_cnt. After bit DATA_W-1 ends, go to PARITY if PAR_EN = 1, else to STOP.
  - PARITY: expected parity = (XOR of the data bits) XOR PAR_TYP. A mismatch sets an internal par_fail flag. Go to STOP at the end of the period.
  - STOP: one bit period, or two if STOP2 = 1. Any stop sample of 0 sets stp_fail. Go to IDLE at the end of the final stop bit period.
- Completion: in the cycle after the final stop bit period ends, exactly one of these applies:
  - No failure: DATA_VLD = 1 and P_DATA updates.
  - par_fail: Par_Err = 1.
  - stp_fail: Stp_Err = 1.
  - Both failures: Par_Err and Stp_Err assert together, with DATA_VLD = 0.
- P_DATA holds its last good value until the next good frame. A failed frame leaves P_DATA unchanged.
- Back-to-back frames: IDLE reacts to rx_s = 0 in the same cycle as the completion strobe, so zero idle bits between frames are supported.
- Frame length in CLK cycles = P * (2 + DATA_W + PAR_EN + STOP2).
- Latency: the strobe appears at RX_IN-to-frame-end + 2 synchroniser cycles + 1.
- Illegal PRESCALE values are undefined; no error is reported for them.

Test Plan:
- Good frame, even parity: DATA_W=8, P=32, PAR_EN=1, PAR_TYP=0, byte 0xA5 with parity bit 0, 1 stop bit -> one DATA_VLD with P_DATA=0xA5. No error strobes.
- Bad parity: same frame but with parity bit 1 -> Par_Err for 1 cycle. DATA_VLD=0 and P_DATA keeps its prior value.
- Stop error: P=16, PAR_EN=0, STOP2=1, byte 0x3C with the second stop bit driven 0 -> Stp_Err for 1 cycle. No DATA_VLD.
- Start glitch: RX_IN low for 4 cycles at P=32 -> FSM returns to IDLE. No strobes; BUSY drops within P/2+2 cycles.
- Wide data, back to back: DATA_W=9, P=8, odd parity, frames 0x1FF then 0x001 with no idle bit between -> two DATA_VLD pulses exactly 8*12 = 96 cycles apart, values 0x1FF then 0x001.
- Reset mid-frame: RST low during DATA bit 3 -> all outputs return to 0 at once, with no strobe. A subsequent frame 0x5A is received correctly.
